mat_result_streamer: RTL

Drains a parallel N x N result matrix, as produced by the team's matrix-multiply array, into a serial valid/ready word stream in row-major order. On a start strobe it snapshots the whole matrix, then emits one element per accepted beat, with row/column tags and a last flag. It sits between the matrix-multiply array and any downstream serial consumer (FIFO, bus bridge, testbench monitor), so the array is free to compute the next result while the stream drains.

---
 rtl/mat_result_streamer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mat_result_streamer.sv
// Snapshots an N x N result matrix on start and streams it row-major over valid/ready.
// Define MAT_STREAM_CHECKSUM_EN to append a modulo-2^DW checksum beat to every frame.
module mat_result_streamer #(
  parameter int N  = 2,
  parameter int DW = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  int            mat_in [0:N-1][0:N-1],
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          out_last,
  output logic          out_cksum,
  output logic          done
);

`ifdef MAT_STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, STREAM, CKSUM} state_t;
`else
  typedef enum logic {IDLE, STREAM} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] snap_q [0:N-1][0:N-1];
  logic          capture;
  logic          busy_q, busy_d, valid_q, valid_d, last_q, last_d;
  logic          cksum_q, cksum_d, done_q, done_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d;
  logic [IW-1:0] next_row, next_col;
  logic          xfer, last_elem;
`ifdef MAT_STREAM_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  assign xfer      = valid_q && out_ready;
  assign last_elem = (row_q == IW'(N - 1)) && (col_q == IW'(N - 1));

  always_comb begin
    next_row = row_q;
    next_col = col_q + IW'(1);
    if (col_q == IW'(N - 1)) begin
      next_col = '0;
      next_row = row_q + IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    cksum_d = cksum_q;
    done_d  = 1'b0;
    capture = 1'b0;
`ifdef MAT_STREAM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = STREAM;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          data_d  = mat_in[0][0][DW-1:0];
          row_d   = '0;
          col_d   = '0;
`ifdef MAT_STREAM_CHECKSUM_EN
          last_d  = 1'b0;
          sum_d   = '0;
`else
          last_d  = 1'(N == 1);
`endif
        end
      end
      STREAM: begin
        if (xfer) begin
`ifdef MAT_STREAM_CHECKSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (last_elem) begin
`ifdef MAT_STREAM_CHECKSUM_EN
            state_d = CKSUM;
            data_d  = sum_q + data_q;
            cksum_d = 1'b1;
            last_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
`else
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            data_d  = '0;
            row_d   = '0;
            col_d   = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            row_d  = next_row;
            col_d  = next_col;
            data_d = snap_q[next_row][next_col];
`ifdef MAT_STREAM_CHECKSUM_EN
            last_d = 1'b0;
`else
            last_d = (next_row == IW'(N - 1)) && (next_col == IW'(N - 1));
`endif
          end
        end
      end
`ifdef MAT_STREAM_CHECKSUM_EN
      CKSUM: begin
        if (xfer) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          data_d  = '0;
          last_d  = 1'b0;
          cksum_d = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      cksum_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef MAT_STREAM_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      cksum_q <= cksum_d;
      done_q  <= done_d;
`ifdef MAT_STREAM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Snapshot frees the upstream array to start on the next result immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          snap_q[i][j] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          snap_q[i][j] <= mat_in[i][j][DW-1:0];
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign out_cksum = cksum_q;
  assign done      = done_q;

endmodule
